// File: rtl/branch_resolver_if.sv
// Prediction / resolve bus between fetch, execute and the branch resolver.
// master = pipeline side driving predictions and resolves, slave = resolver.
interface branch_resolver_if;
    logic        pred_valid;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic [15:0] pred_fall;
    logic [15:0] pred_psw;
    logic        pred_ready;
    logic        ex_valid;
    logic [2:0]  ex_cond;
    logic [3:0]  psw_flags;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] redirect_psw;
    logic        flush;
    logic        q_empty;

    modport master (
        output pred_valid, pred_taken, pred_target, pred_fall, pred_psw,
        output ex_valid, ex_cond, psw_flags,
        input  pred_ready, redirect, redirect_pc, redirect_psw, flush, q_empty
    );

    modport slave (
        input  pred_valid, pred_taken, pred_target, pred_fall, pred_psw,
        input  ex_valid, ex_cond, psw_flags,
        output pred_ready, redirect, redirect_pc, redirect_psw, flush, q_empty
    );
endinterface

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: prediction FIFO, condition check, PC/PSW restore and flush window.
// Optional BRANCH_RESOLVER_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolver #(
    parameter int DEPTH        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    branch_resolver_if.slave   bus
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [15:0]        stat_resolved,
    output logic [15:0]        stat_mispred
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int QCNT_W = PTR_W + 1;
    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    typedef struct packed {
        logic        taken;
        logic [15:0] target;
        logic [15:0] fall;
        logic [15:0] psw;
    } entry_t;

    // Flags are packed {V,N,Z,C}; code 7 is branch-always.
    function automatic logic cond_eval(input logic [2:0] code, input logic [3:0] flags);
        logic v, n, z, c, res;
        {v, n, z, c} = flags;
        case (code)
            3'd0:    res = z;
            3'd1:    res = ~z;
            3'd2:    res = c;
            3'd3:    res = ~c;
            3'd4:    res = n;
            3'd5:    res = (n == v);
            3'd6:    res = (n != v);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    entry_t                mem_r [DEPTH];
    state_t                state_r, state_s;
    logic [FCNT_W-1:0]     fcnt_r, fcnt_s;
    logic [PTR_W-1:0]      rd_ptr_r, rd_ptr_s, wr_ptr_r, wr_ptr_s;
    logic [QCNT_W-1:0]     count_r, count_s;
    logic                  redirect_r, redirect_s;
    logic [15:0]           redirect_pc_r, redirect_pc_s;
    logic [15:0]           redirect_psw_r, redirect_psw_s;
    logic                  flush_r, flush_s;
    logic                  ready_r, ready_s;
    logic                  empty_r, empty_s;
    entry_t                head_s;
    logic                  actual_s, pop_s, push_s, mispred_s, wr_en_s;

    // Next-state, queue bookkeeping and resolve decision.
    always_comb begin
        head_s         = mem_r[rd_ptr_r];
        actual_s       = cond_eval(bus.ex_cond, bus.psw_flags);
        pop_s          = 1'b0;
        push_s         = 1'b0;
        mispred_s      = 1'b0;
        state_s        = state_r;
        fcnt_s         = fcnt_r;
        rd_ptr_s       = rd_ptr_r;
        wr_ptr_s       = wr_ptr_r;
        count_s        = count_r;
        redirect_s     = 1'b0;
        redirect_pc_s  = redirect_pc_r;
        redirect_psw_s = redirect_psw_r;
        flush_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pop_s     = bus.ex_valid && (count_r != {QCNT_W{1'b0}});
                push_s    = bus.pred_valid && ready_r;
                mispred_s = pop_s && (actual_s != head_s.taken);
                if (mispred_s) begin
                    // Everything younger than the head is wrong-path, same-cycle push included.
                    state_s        = ST_FLUSH;
                    fcnt_s         = FCNT_W'(FLUSH_CYCLES - 1);
                    rd_ptr_s       = {PTR_W{1'b0}};
                    wr_ptr_s       = {PTR_W{1'b0}};
                    count_s        = {QCNT_W{1'b0}};
                    flush_s        = 1'b1;
                    redirect_s     = 1'b1;
                    redirect_pc_s  = actual_s ? head_s.target : head_s.fall;
                    redirect_psw_s = head_s.psw;
                end else begin
                    if (pop_s) begin
                        rd_ptr_s = rd_ptr_r + PTR_W'(1);
                    end else begin
                        rd_ptr_s = rd_ptr_r;
                    end
                    if (push_s) begin
                        wr_ptr_s = wr_ptr_r + PTR_W'(1);
                    end else begin
                        wr_ptr_s = wr_ptr_r;
                    end
                    case ({push_s, pop_s})
                        2'b10:   count_s = count_r + QCNT_W'(1);
                        2'b01:   count_s = count_r - QCNT_W'(1);
                        default: count_s = count_r;
                    endcase
                end
            end
            ST_FLUSH: begin
                if (fcnt_r == {FCNT_W{1'b0}}) begin
                    state_s = ST_IDLE;
                    flush_s = 1'b0;
                end else begin
                    fcnt_s  = fcnt_r - FCNT_W'(1);
                    flush_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                flush_s = 1'b0;
            end
        endcase
        wr_en_s = push_s && !mispred_s;
        ready_s = (state_s == ST_IDLE) && (count_s != QCNT_W'(DEPTH));
        empty_s = (count_s == {QCNT_W{1'b0}});
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            fcnt_r         <= {FCNT_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            wr_ptr_r       <= {PTR_W{1'b0}};
            count_r        <= {QCNT_W{1'b0}};
            redirect_r     <= 1'b0;
            redirect_pc_r  <= 16'h0000;
            redirect_psw_r <= 16'h0000;
            flush_r        <= 1'b0;
            ready_r        <= 1'b1;
            empty_r        <= 1'b1;
        end else begin
            state_r        <= state_s;
            fcnt_r         <= fcnt_s;
            rd_ptr_r       <= rd_ptr_s;
            wr_ptr_r       <= wr_ptr_s;
            count_r        <= count_s;
            redirect_r     <= redirect_s;
            redirect_pc_r  <= redirect_pc_s;
            redirect_psw_r <= redirect_psw_s;
            flush_r        <= flush_s;
            ready_r        <= ready_s;
            empty_r        <= empty_s;
        end
    end

    // Prediction storage; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_r[wr_ptr_r] <= '{taken:  bus.pred_taken,  target: bus.pred_target,
                                 fall:   bus.pred_fall,   psw:    bus.pred_psw};
        end
    end

    assign bus.pred_ready   = ready_r;
    assign bus.q_empty      = empty_r;
    assign bus.flush        = flush_r;
    assign bus.redirect     = redirect_r;
    assign bus.redirect_pc  = redirect_pc_r;
    assign bus.redirect_psw = redirect_psw_r;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] stat_resolved_r, stat_mispred_r;

    // Saturating resolve/mispredict counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved_r <= 16'h0000;
            stat_mispred_r  <= 16'h0000;
        end else begin
            if (pop_s && (stat_resolved_r != 16'hFFFF)) begin
                stat_resolved_r <= stat_resolved_r + 16'd1;
            end
            if (mispred_s && (stat_mispred_r != 16'hFFFF)) begin
                stat_mispred_r <= stat_mispred_r + 16'd1;
            end
        end
    end

    assign stat_resolved = stat_resolved_r;
    assign stat_mispred  = stat_mispred_r;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized and directed bench for branch_resolver against a queue-based reference model.
module tb_branch_resolver;
    localparam int DEPTH        = 2;
    localparam int FLUSH_CYCLES = 2;

    logic clk;
    logic rst;
    branch_resolver_if bus_if ();
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] stat_resolved, stat_mispred;
`endif

    branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .stat_resolved(stat_resolved),
        .stat_mispred(stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          taken;
        logic [15:0] tgt;
        logic [15:0] fall;
        logic [15:0] psw;
    } ent_t;

    ent_t        mq[$];
    int          flush_rem;
    bit          m_redirect;
    logic [15:0] m_pc, m_psw;
    int          m_resolved, m_mispred;
    int          total, bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit branch_taken(input logic [2:0] c, input logic [3:0] f);
        bit v, n, z, cy;
        v = f[3]; n = f[2]; z = f[1]; cy = f[0];
        case (c)
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return cy;
            3'd3:    return !cy;
            3'd4:    return n;
            3'd5:    return n == v;
            3'd6:    return n != v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        flush_rem  = 0;
        m_redirect = 1'b0;
        m_pc       = 16'h0000;
        m_psw      = 16'h0000;
        m_resolved = 0;
        m_mispred  = 0;
    endtask

    // One clock: drive inputs, advance the model over the edge, compare all outputs.
    task automatic step(input bit r, input bit pv, input bit pt, input logic [15:0] tgt,
                        input logic [15:0] fall, input logic [15:0] psw, input bit exv,
                        input logic [2:0] c, input logic [3:0] fl);
        bit   push, pop;
        ent_t e;
        rst                = r;
        bus_if.pred_valid  = pv;
        bus_if.pred_taken  = pt;
        bus_if.pred_target = tgt;
        bus_if.pred_fall   = fall;
        bus_if.pred_psw    = psw;
        bus_if.ex_valid    = exv;
        bus_if.ex_cond     = c;
        bus_if.psw_flags   = fl;
        @(posedge clk);
        m_redirect = 1'b0;
        if (r) begin
            model_reset();
        end else if (flush_rem > 0) begin
            flush_rem--;
        end else begin
            push = pv && (mq.size() < DEPTH);
            pop  = exv && (mq.size() > 0);
            if (pop) begin
                e = mq.pop_front();
                m_resolved++;
                if (branch_taken(c, fl) != e.taken) begin
                    m_mispred++;
                    m_redirect = 1'b1;
                    m_pc       = branch_taken(c, fl) ? e.tgt : e.fall;
                    m_psw      = e.psw;
                    mq.delete();
                    flush_rem  = FLUSH_CYCLES;
                    push       = 1'b0;
                end
            end
            if (push) mq.push_back('{taken: pt, tgt: tgt, fall: fall, psw: psw});
        end
        #1;
        chk("redirect",     32'(bus_if.redirect),     32'(m_redirect));
        chk("redirect_pc",  32'(bus_if.redirect_pc),  32'(m_pc));
        chk("redirect_psw", 32'(bus_if.redirect_psw), 32'(m_psw));
        chk("flush",        32'(bus_if.flush),        32'(flush_rem > 0));
        chk("pred_ready",   32'(bus_if.pred_ready),   32'((flush_rem == 0) && (mq.size() < DEPTH)));
        chk("q_empty",      32'(bus_if.q_empty),      32'(mq.size() == 0));
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat_resolved", 32'(stat_resolved), 32'(m_resolved > 65535 ? 65535 : m_resolved));
        chk("stat_mispred",  32'(stat_mispred),  32'(m_mispred > 65535 ? 65535 : m_mispred));
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd7, 4'h0);
    endtask

    task automatic push(input bit pt, input logic [15:0] tgt, input logic [15:0] fall,
                        input logic [15:0] psw);
        step(1'b0, 1'b1, pt, tgt, fall, psw, 1'b0, 3'd7, 4'h0);
    endtask

    task automatic resolve(input logic [2:0] c, input logic [3:0] fl);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, c, fl);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();

        // Reset for two clocks.
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 4'h0);
        chk("rst_ready", 32'(bus_if.pred_ready), 32'd1);
        chk("rst_empty", 32'(bus_if.q_empty),    32'd1);
        chk("rst_flush", 32'(bus_if.flush),      32'd0);

        // Correct taken prediction resolved with AL.
        push(1'b1, 16'h0120, 16'h0102, 16'h0000);
        resolve(3'd7, 4'h0);
        chk("ok_redirect", 32'(bus_if.redirect), 32'd0);
        chk("ok_empty",    32'(bus_if.q_empty),  32'd1);

        // Taken mispredict: EQ with Z=0.
        push(1'b1, 16'h0200, 16'h0104, 16'h00E3);
        resolve(3'd0, 4'b0000);
        chk("mp_redirect", 32'(bus_if.redirect),     32'd1);
        chk("mp_pc",       32'(bus_if.redirect_pc),  32'h0104);
        chk("mp_psw",      32'(bus_if.redirect_psw), 32'h00E3);
        chk("mp_flush1",   32'(bus_if.flush),        32'd1);
        idle();
        chk("mp_flush2",   32'(bus_if.flush),        32'd1);
        chk("mp_pulse",    32'(bus_if.redirect),     32'd0);
        idle();
        chk("mp_flush3",   32'(bus_if.flush),        32'd0);
        chk("mp_empty",    32'(bus_if.q_empty),      32'd1);

        // Not-taken mispredict: GE with V=1, N=1.
        push(1'b0, 16'h0080, 16'h0042, 16'h0011);
        resolve(3'd5, 4'b1100);
        chk("nt_pc", 32'(bus_if.redirect_pc), 32'h0080);
        idle();
        idle();

        // Fill, drop, pop+push, then discard on mispredict.
        push(1'b1, 16'h0300, 16'h0202, 16'h0001);
        push(1'b1, 16'h0310, 16'h0212, 16'h0002);
        chk("full_ready", 32'(bus_if.pred_ready), 32'd0);
        push(1'b1, 16'h0320, 16'h0222, 16'h0003);
        step(1'b0, 1'b1, 1'b1, 16'h0330, 16'h0232, 16'h0004, 1'b1, 3'd7, 4'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0340, 16'h0242, 16'h0005, 1'b1, 3'd7, 4'h0);
        chk("pp_empty", 32'(bus_if.q_empty), 32'd0);
        push(1'b0, 16'h0350, 16'h0252, 16'h0006);
        chk("full2_ready", 32'(bus_if.pred_ready), 32'd0);
        resolve(3'd0, 4'b0000);
        chk("disc_pc",    32'(bus_if.redirect_pc), 32'h0242);
        chk("disc_empty", 32'(bus_if.q_empty),     32'd1);
        idle();
        idle();

        // Reset during the first flush cycle aborts the flush.
        push(1'b0, 16'h0400, 16'h0302, 16'h0007);
        resolve(3'd7, 4'h0);
        chk("ab_flush_before", 32'(bus_if.flush), 32'd1);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 4'h0);
        chk("ab_flush", 32'(bus_if.flush),      32'd0);
        chk("ab_ready", 32'(bus_if.pred_ready), 32'd1);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199) == 0, $urandom_range(1), $urandom_range(1),
                 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(2) == 0,
                 3'($urandom_range(7)), 4'($urandom_range(15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
